mem_axi_rd_arb: RTL and testbench
=================================

Name: mem_axi_rd_arb

Overview:
- Two-client read arbiter for the 64-bit MEM_AXI memory port of the SoC wrapper.
- Clients are, for example, an instruction-refill engine and a debug/DMA reader. Each presents a simplified AR/R interface.
- The block grants the shared AXI4 read channel round-robin, with one outstanding burst at a time. It routes R beats back to the granted client and checks burst length.

Parameters:
- ADDR_W, 64, address width of clients and MEM_AXI_ARADDR
- DATA_W, 64, data width of MEM_AXI_RDATA and c_rdata
- ID_W, 4, width of MEM_AXI_ARID/RID

Ports:
- sys_clk  in  1  single clock; every register in the block is clocked on its rising edge
- RSTn  in  1  asynchronous, active-low reset
- c_arvalid  in  2  per-client read request valid; bit i belongs to client i
- c_arready  out  2  per-client request accept
- c_araddr  in  2*ADDR_W  client address; client i uses slice [i*ADDR_W +: ADDR_W]
- c_arlen  in  16  client burst length-1; client i uses [i*8 +: 8]
- c_arsize  in  6  client beat size; client i uses [i*3 +: 3]
- c_rdata  out  DATA_W  read data, broadcast to both clients
- c_rresp  out  2  read response, broadcast
- c_rlast  out  1  last beat, broadcast
- c_rvalid  out  2  per-client beat valid; only the granted bit can be high
- c_rready  in  2  per-client beat ready
- len_err  out  1  one-cycle pulse on a burst-length mismatch
- MEM_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARVALID  out  ID_W/ADDR_W/8/3/2/1/4/3/1  AXI4 AR master channel
- MEM_AXI_ARREADY  in  1  AXI4 AR ready
- MEM_AXI_RID/RDATA/RRESP/RLAST/RVALID  in  ID_W/DATA_W/2/1/1  AXI4 R channel
- MEM_AXI_RREADY  out  1  AXI4 R ready

Behaviour:
- State machine: IDLE, ADDR, DATA.
- Registers: state, gnt (1 bit), last_gnt (1 bit), ar_addr, ar_len, ar_size, beat_cnt (8 bit), len_err.

Reset (RSTn low, asynchronous):
- state=IDLE, last_gnt=1 so client 0 wins the first tie.
- gnt=0, beat_cnt=0, len_err=0.
- MEM_AXI_ARVALID=0, MEM_AXI_RREADY=0, c_arready=0, c_rvalid=0.
- ar_addr/ar_len/ar_size are cleared to 0.

IDLE:
- Arbitration is combinational. If only one c_arvalid bit is high, that client wins. If both are high, the client != last_gnt wins.
- c_arready[win]=1 in the same cycle, so client acceptance is zero-latency. The other bit stays 0.
- On acceptance, the winning client's addr/len/size are registered, gnt<=win, beat_cnt<=0, and the state goes to ADDR.
- If no request is present, the state stays IDLE and all c_arready bits are 0.

ADDR:
- MEM_AXI_ARVALID=1 and stays asserted until MEM_AXI_ARREADY; the AR fields are held stable from the registers.
- Field values:
  - ARID = {ID_W-1 zeros, gnt}
  - ARBURST = 2'b01 (INCR)
  - ARLOCK = 0
  - ARCACHE = 4'b0011
  - ARPROT = 3'b000
- On ARVALID&ARREADY the state goes to DATA. The earliest AR handshake is one cycle after client acceptance.
- No client is accepted in ADDR or DATA.

DATA:
- Routing is combinational: c_rvalid[gnt]=MEM_AXI_RVALID, c_rvalid[~gnt]=0, MEM_AXI_RREADY=c_rready[gnt].
- c_rdata, c_rresp and c_rlast pass straight through from RDATA, RRESP and RLAST.
- On each beat (RVALID&RREADY): beat_cnt<=beat_cnt+1, 8-bit arithmetic.
- A beat with RLAST=1 ends the burst: state<=IDLE, last_gnt<=gnt.
- len_err pulses for exactly one cycle, registered, in the cycle after the offending beat, in either of two cases:
  - RLAST=1 while beat_cnt!=ar_len
  - a beat with beat_cnt==ar_len has RLAST=0. beat_cnt then wraps at 255 and the burst still waits for RLAST.
- RID is not checked.
- ARVALID is 0 throughout DATA.

Boundary conditions:
- Back-to-back bursts: a request present in the cycle after RLAST is accepted immediately from IDLE, giving one dead cycle per burst.
- A client that deasserts c_arvalid in IDLE before acceptance is simply not granted.
- ARLEN=0 gives a single-beat burst; RLAST on beat 0 is legal.
- If RSTn falls mid-burst, the block returns to IDLE immediately. The outstanding AXI transaction is abandoned, which is legal only under a system-wide reset.

Test Plan:
- Single request: client 0 requests addr=0x8000_0000, len=3; ARREADY high. Required: c_arready[0] pulses in cycle 0, ARVALID in cycle 1 with ARID=0 and ARLEN=3, 4 beats reach c_rvalid[0] only, c_rvalid[1]=0, state returns to IDLE after RLAST, len_err=0.
- Tie after reset: both clients request in the same cycle. Required: client 0 granted first, then client 1 (ARID=1), then client 0 again while both keep requesting.
- AR backpressure: ARREADY held low for 5 cycles. Required: ARVALID stays high with ARADDR/ARLEN stable, c_arready stays 0 for both clients, and AR completes on the 6th cycle.
- R backpressure: client 1 burst with len=1; c_rready[1] toggles 1,0,1. Required: MEM_AXI_RREADY mirrors c_rready[1], 2 beats are counted, and the state returns to IDLE only after the second beat.
- Length mismatch: len=3 with slave RLAST on beat 1. Required: len_err=1 for exactly one cycle after that beat; state IDLE. A second test with len=0 and RLAST on beat 1 gives len_err after beat 0.
- Reset mid-burst: RSTn low during DATA beat 2. Required: ARVALID, RREADY, c_rvalid and c_arready all go to 0 asynchronously; after release the block is in IDLE with client 0 winning the first tie.

Source files
------------

// File: rtl/mem_axi_rd_arb.sv
// Two-client round-robin read arbiter for the 64-bit MEM_AXI port.
// It allows one outstanding burst at a time and flags a mismatch between the burst length and RLAST.
module mem_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                sys_clk,
  input  logic                RSTn,
  input  logic [1:0]          c_arvalid,
  output logic [1:0]          c_arready,
  input  logic [2*ADDR_W-1:0] c_araddr,
  input  logic [15:0]         c_arlen,
  input  logic [5:0]          c_arsize,
  output logic [DATA_W-1:0]   c_rdata,
  output logic [1:0]          c_rresp,
  output logic                c_rlast,
  output logic [1:0]          c_rvalid,
  input  logic [1:0]          c_rready,
  output logic                len_err,
  output logic [ID_W-1:0]     MEM_AXI_ARID,
  output logic [ADDR_W-1:0]   MEM_AXI_ARADDR,
  output logic [7:0]          MEM_AXI_ARLEN,
  output logic [2:0]          MEM_AXI_ARSIZE,
  output logic [1:0]          MEM_AXI_ARBURST,
  output logic                MEM_AXI_ARLOCK,
  output logic [3:0]          MEM_AXI_ARCACHE,
  output logic [2:0]          MEM_AXI_ARPROT,
  output logic                MEM_AXI_ARVALID,
  input  logic                MEM_AXI_ARREADY,
  input  logic [ID_W-1:0]     MEM_AXI_RID,
  input  logic [DATA_W-1:0]   MEM_AXI_RDATA,
  input  logic [1:0]          MEM_AXI_RRESP,
  input  logic                MEM_AXI_RLAST,
  input  logic                MEM_AXI_RVALID,
  output logic                MEM_AXI_RREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state;
  logic                gnt;
  logic                last_gnt;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [7:0]          beat_cnt;
  logic                win;
  logic                accept;
  logic                beat;
  logic                unused_rid;

  // RID is deliberately ignored: only one burst is ever outstanding.
  assign unused_rid = ^MEM_AXI_RID;

  always_comb begin
    win = (c_arvalid == 2'b11) ? ~last_gnt : c_arvalid[1];
  end

  assign accept = (state == IDLE) && (|c_arvalid);
  assign beat   = (state == DATA) && MEM_AXI_RVALID && MEM_AXI_RREADY;

  // The accept strobe is gated by reset so that a request held across reset is never acknowledged.
  always_comb begin
    c_arready = '0;
    if (accept && RSTn) c_arready[win] = 1'b1;
  end

  always_comb begin
    c_rvalid = '0;
    if (state == DATA) c_rvalid[gnt] = MEM_AXI_RVALID;
  end

  assign MEM_AXI_RREADY  = (state == DATA) && c_rready[gnt];
  assign c_rdata         = MEM_AXI_RDATA;
  assign c_rresp         = MEM_AXI_RRESP;
  assign c_rlast         = MEM_AXI_RLAST;

  assign MEM_AXI_ARVALID = (state == ADDR);
  assign MEM_AXI_ARID    = {{(ID_W-1){1'b0}}, gnt};
  assign MEM_AXI_ARADDR  = ar_addr;
  assign MEM_AXI_ARLEN   = ar_len;
  assign MEM_AXI_ARSIZE  = ar_size;
  assign MEM_AXI_ARBURST = 2'b01;
  assign MEM_AXI_ARLOCK  = 1'b0;
  assign MEM_AXI_ARCACHE = 4'b0011;
  assign MEM_AXI_ARPROT  = 3'b000;

  always_ff @(posedge sys_clk or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            gnt      <= win;
            ar_addr  <= win ? c_araddr[2*ADDR_W-1 -: ADDR_W] : c_araddr[ADDR_W-1:0];
            ar_len   <= win ? c_arlen[15:8] : c_arlen[7:0];
            ar_size  <= win ? c_arsize[5:3] : c_arsize[2:0];
            beat_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (MEM_AXI_ARREADY) state <= DATA;
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            len_err  <= MEM_AXI_RLAST ? (beat_cnt != ar_len) : (beat_cnt == ar_len);
            if (MEM_AXI_RLAST) begin
              state    <= IDLE;
              last_gnt <= gnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_rd_arb.sv
// Scoreboard bench for mem_axi_rd_arb: expected AR requests, R beats and len_err pulses are queued as
// stimulus is driven, then compared against what the DUT presents.
module tb_mem_axi_rd_arb;

  logic          sys_clk = 1'b0;
  logic          RSTn;
  logic [1:0]    c_arvalid;
  logic [1:0]    c_arready;
  logic [127:0]  c_araddr;
  logic [15:0]   c_arlen;
  logic [5:0]    c_arsize;
  logic [63:0]   c_rdata;
  logic [1:0]    c_rresp;
  logic          c_rlast;
  logic [1:0]    c_rvalid;
  logic [1:0]    c_rready;
  logic          len_err;
  logic [3:0]    MEM_AXI_ARID;
  logic [63:0]   MEM_AXI_ARADDR;
  logic [7:0]    MEM_AXI_ARLEN;
  logic [2:0]    MEM_AXI_ARSIZE;
  logic [1:0]    MEM_AXI_ARBURST;
  logic          MEM_AXI_ARLOCK;
  logic [3:0]    MEM_AXI_ARCACHE;
  logic [2:0]    MEM_AXI_ARPROT;
  logic          MEM_AXI_ARVALID;
  logic          MEM_AXI_ARREADY;
  logic [3:0]    MEM_AXI_RID;
  logic [63:0]   MEM_AXI_RDATA;
  logic [1:0]    MEM_AXI_RRESP;
  logic          MEM_AXI_RLAST;
  logic          MEM_AXI_RVALID;
  logic          MEM_AXI_RREADY;

  always #5 sys_clk = ~sys_clk;

  mem_axi_rd_arb #(.ADDR_W(64), .DATA_W(64), .ID_W(4)) dut (
    .sys_clk(sys_clk), .RSTn(RSTn),
    .c_arvalid(c_arvalid), .c_arready(c_arready), .c_araddr(c_araddr),
    .c_arlen(c_arlen), .c_arsize(c_arsize),
    .c_rdata(c_rdata), .c_rresp(c_rresp), .c_rlast(c_rlast),
    .c_rvalid(c_rvalid), .c_rready(c_rready), .len_err(len_err),
    .MEM_AXI_ARID(MEM_AXI_ARID), .MEM_AXI_ARADDR(MEM_AXI_ARADDR),
    .MEM_AXI_ARLEN(MEM_AXI_ARLEN), .MEM_AXI_ARSIZE(MEM_AXI_ARSIZE),
    .MEM_AXI_ARBURST(MEM_AXI_ARBURST), .MEM_AXI_ARLOCK(MEM_AXI_ARLOCK),
    .MEM_AXI_ARCACHE(MEM_AXI_ARCACHE), .MEM_AXI_ARPROT(MEM_AXI_ARPROT),
    .MEM_AXI_ARVALID(MEM_AXI_ARVALID), .MEM_AXI_ARREADY(MEM_AXI_ARREADY),
    .MEM_AXI_RID(MEM_AXI_RID), .MEM_AXI_RDATA(MEM_AXI_RDATA),
    .MEM_AXI_RRESP(MEM_AXI_RRESP), .MEM_AXI_RLAST(MEM_AXI_RLAST),
    .MEM_AXI_RVALID(MEM_AXI_RVALID), .MEM_AXI_RREADY(MEM_AXI_RREADY)
  );

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [88:0]   ar_q [$];
  logic [66:0]   r_q [$];
  logic [63:0]   ca_addr [2];
  logic [7:0]    ca_len [2];
  logic [2:0]    ca_size [2];
  int            model_last;
  int            cur_c;
  logic [7:0]    cur_len;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic accept(input logic [1:0] req, input bit hold);
    int w;
    logic [1:0] e;
    @(negedge sys_clk);
    c_araddr = {ca_addr[1], ca_addr[0]};
    c_arlen  = {ca_len[1], ca_len[0]};
    c_arsize = {ca_size[1], ca_size[0]};
    c_arvalid = req;
    #1;
    w = (req == 2'b11) ? ((model_last == 0) ? 1 : 0) : (req[1] ? 1 : 0);
    e = 2'b01 << w;
    check("c_arready_win", c_arready, e);
    ar_q.push_back({4'(w), ca_addr[w], ca_len[w], ca_size[w], 2'b01, 1'b0, 4'b0011, 3'b000});
    cur_c = w;
    cur_len = ca_len[w];
    @(posedge sys_clk);
    #1;
    check("len_err_clear", len_err, 1'b0);
    if (!hold) c_arvalid = '0;
  endtask

  task automatic ar_phase(input int stall);
    logic [88:0] e;
    if (ar_q.size() == 0) begin
      check("ar_q_nonempty", 1'b0, 1'b1);
      return;
    end
    e = ar_q.pop_front();
    for (int i = 0; i <= stall; i++) begin
      @(negedge sys_clk);
      MEM_AXI_ARREADY = (i == stall);
      MEM_AXI_RVALID = 1'b1;
      c_rready = 2'b11;
      #1;
      check("arvalid", MEM_AXI_ARVALID, 1'b1);
      check("ar_fields", {MEM_AXI_ARID, MEM_AXI_ARADDR, MEM_AXI_ARLEN, MEM_AXI_ARSIZE,
                          MEM_AXI_ARBURST, MEM_AXI_ARLOCK, MEM_AXI_ARCACHE, MEM_AXI_ARPROT}, e);
      check("c_arready_busy", c_arready, 2'b00);
      check("c_rvalid_addr", c_rvalid, 2'b00);
      check("rready_addr", MEM_AXI_RREADY, 1'b0);
    end
    @(posedge sys_clk);
    #1;
    MEM_AXI_ARREADY = 1'b0;
    MEM_AXI_RVALID = 1'b0;
    c_rready = 2'b00;
  endtask

  task automatic r_burst(input int nbeats, input int last_at, input logic [7:0] rr_pat);
    int b = 0;
    int k = 0;
    logic [7:0] cnt = 8'd0;
    logic hs, exp_err;
    logic [1:0] e;
    while (b < nbeats && k < 32) begin
      @(negedge sys_clk);
      MEM_AXI_RVALID = 1'b1;
      MEM_AXI_RDATA = {$urandom, $urandom};
      MEM_AXI_RRESP = 2'(b);
      MEM_AXI_RLAST = (b == last_at);
      MEM_AXI_RID = 4'($urandom);
      c_rready[cur_c] = (k < 8) ? rr_pat[k] : 1'b1;
      c_rready[1 - cur_c] = 1'b1;
      r_q.push_back({MEM_AXI_RDATA, MEM_AXI_RRESP, MEM_AXI_RLAST});
      #1;
      e = 2'b01 << cur_c;
      check("c_rvalid", c_rvalid, e);
      check("mem_rready", MEM_AXI_RREADY, c_rready[cur_c]);
      if (c_rvalid[cur_c]) check("r_payload", {c_rdata, c_rresp, c_rlast}, r_q.pop_front());
      hs = c_rready[cur_c];
      exp_err = hs && (MEM_AXI_RLAST ? (cnt != cur_len) : (cnt == cur_len));
      if (hs) begin
        if (MEM_AXI_RLAST) model_last = cur_c;
        cnt++;
        b++;
      end
      @(posedge sys_clk);
      #1;
      check("len_err", len_err, exp_err);
      k++;
    end
    r_q.delete();
    MEM_AXI_RVALID = 1'b0;
    MEM_AXI_RLAST = 1'b0;
    c_rready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0;
    c_arvalid = 2'b11;
    c_araddr = '0; c_arlen = '0; c_arsize = '0; c_rready = '0;
    MEM_AXI_ARREADY = 0; MEM_AXI_RID = '0; MEM_AXI_RDATA = '0;
    MEM_AXI_RRESP = '0; MEM_AXI_RLAST = 0; MEM_AXI_RVALID = 1'b1;
    ca_addr[0] = 64'h0000_0000_8000_0000; ca_len[0] = 8'd0; ca_size[0] = 3'd3;
    ca_addr[1] = 64'h0000_0000_9000_1000; ca_len[1] = 8'd1; ca_size[1] = 3'd3;
    model_last = 1;
    cur_c = 0;
    cur_len = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_arvalid", MEM_AXI_ARVALID, 1'b0);
    check("rst_rready", MEM_AXI_RREADY, 1'b0);
    check("rst_c_arready", c_arready, 2'b00);
    check("rst_c_rvalid", c_rvalid, 2'b00);
    check("rst_len_err", len_err, 1'b0);
    c_arvalid = '0;
    MEM_AXI_RVALID = 1'b0;
    RSTn = 1'b1;

    // Tie after reset: 0, then 1, then 0 while both keep requesting, with back-to-back bursts.
    accept(2'b11, 1); ar_phase(0); r_burst(1, 0, 8'hFF);
    accept(2'b11, 1); ar_phase(0); r_burst(2, 1, 8'hFF);
    accept(2'b11, 0); ar_phase(0); r_burst(1, 0, 8'hFF);

    // Single request from client 0.
    ca_len[0] = 8'd3;
    accept(2'b01, 0); ar_phase(0); r_burst(4, 3, 8'hFF);

    // AR backpressure for five cycles.
    ca_len[1] = 8'd2; ca_addr[1] = 64'h1234_5678_0000_0040; ca_size[1] = 3'd2;
    accept(2'b10, 0); ar_phase(5); r_burst(3, 2, 8'hFF);

    // R backpressure with the client ready pattern 1,0,1.
    ca_len[1] = 8'd1;
    accept(2'b10, 0); ar_phase(0); r_burst(2, 1, 8'b0000_0101);

    // A request withdrawn before the clock edge is not granted.
    @(negedge sys_clk);
    c_arvalid = 2'b10;
    #1 check("withdraw_pre", c_arready, 2'b10);
    #2 c_arvalid = 2'b00;
    #1 check("withdraw_post", c_arready, 2'b00);

    // Length mismatches: an early RLAST, and len 0 with RLAST on beat 1.
    ca_len[0] = 8'd3;
    accept(2'b01, 0); ar_phase(0); r_burst(2, 1, 8'hFF);
    ca_len[1] = 8'd0;
    accept(2'b10, 0); ar_phase(0); r_burst(2, 1, 8'hFF);

    // Reset asserted during data beat 2.
    accept(2'b01, 0); ar_phase(0);
    cur_len = 8'd3;
    r_burst(2, 99, 8'hFF);
    @(negedge sys_clk);
    MEM_AXI_RVALID = 1'b1; c_rready = 2'b11; c_arvalid = 2'b11;
    #1 check("pre_rst_c_rvalid", c_rvalid, 2'b01);
    #1 RSTn = 1'b0;
    #1;
    check("mid_rst_arvalid", MEM_AXI_ARVALID, 1'b0);
    check("mid_rst_rready", MEM_AXI_RREADY, 1'b0);
    check("mid_rst_c_rvalid", c_rvalid, 2'b00);
    check("mid_rst_c_arready", c_arready, 2'b00);
    MEM_AXI_RVALID = 1'b0; c_rready = 2'b00; c_arvalid = 2'b00;
    ar_q.delete();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    RSTn = 1'b1;
    model_last = 1;
    ca_len[0] = 8'd0;
    accept(2'b11, 0); ar_phase(0); r_burst(1, 0, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
